// File: rtl/tff_ctrl.sv
// Controller for a toggle-flip-flop ring-oscillator cell: clears it, writes a
// pulse-length value via tff_we, and times the cell's response via tff_re.
module tff_ctrl #(
    parameter int DATA_W      = 4,
    parameter int UNIT_CYC    = 1,
    parameter int CLR_CYC     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_timeout,
    output logic              tff_we,
    output logic              tff_re,
    output logic              tff_rstb,
    input  logic              tff_out
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PH_W   = DATA_W + 8;
    localparam int WIDE_W = (TMO_W > DATA_W) ? TMO_W : DATA_W;

    localparam logic [PH_W-1:0]   CLR_LAST = PH_W'(CLR_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_VAL  = TMO_W'(TIMEOUT_CYC);
    localparam logic [DATA_W-1:0] RD_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [PH_W-1:0]        ph_cnt_q, ph_cnt_d;
    logic [TMO_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic                   base_q, base_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   rd_timeout_q, rd_timeout_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   busy_q, busy_d;
    logic                   tff_we_q, tff_we_d;
    logic                   tff_re_q, tff_re_d;
    logic                   tff_rstb_q, tff_rstb_d;

    logic                   sync_bit;
    logic                   edge_seen;
    logic [PH_W-1:0]        wr_len;
    logic [TMO_W-1:0]       rd_cnt_inc;
    logic [WIDE_W-1:0]      rd_cnt_wide;

    assign sync_bit    = sync_q[SYNC_STAGES-1];
    assign edge_seen   = (sync_bit != base_q);
    assign wr_len      = PH_W'(wdata_q) * PH_W'(UNIT_CYC);
    assign rd_cnt_inc  = rd_cnt_q + 1'b1;
    assign rd_cnt_wide = WIDE_W'(rd_cnt_inc);

    always_comb begin
        state_d      = state_q;
        wdata_d      = wdata_q;
        ph_cnt_d     = ph_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        base_d       = base_q;
        rd_data_d    = rd_data_q;
        rd_timeout_d = rd_timeout_q;
        rd_valid_d   = 1'b0;
        sync_d       = {sync_q[SYNC_STAGES-2:0], tff_out};

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    wdata_d  = wr_data;
                    ph_cnt_d = '0;
                    state_d  = CLEAR;
                end else if (rd_req) begin
                    base_d   = sync_bit;
                    rd_cnt_d = '0;
                    state_d  = READ;
                end
            end
            CLEAR: begin
                if (ph_cnt_q == CLR_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = (wdata_q == '0) ? IDLE : WRITE;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (ph_cnt_q == wr_len - PH_W'(1)) begin
                    ph_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            READ: begin
                // The counter value carried out is the number of READ cycles
                // spent; an edge in the final timeout cycle still wins.
                rd_cnt_d = rd_cnt_inc;
                if (edge_seen || (rd_cnt_inc == TMO_VAL)) begin
                    state_d      = DONE;
                    rd_valid_d   = 1'b1;
                    rd_timeout_d = ~edge_seen;
                    rd_data_d    = (rd_cnt_wide > WIDE_W'(RD_MAX)) ? RD_MAX
                                                                   : DATA_W'(rd_cnt_wide);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cell controls follow the next state so they line up with it after the edge.
        busy_d     = (state_d != IDLE);
        tff_we_d   = (state_d == WRITE);
        tff_re_d   = (state_d == READ);
        tff_rstb_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            wdata_q      <= '0;
            ph_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            base_q       <= 1'b0;
            sync_q       <= '0;
            rd_data_q    <= '0;
            rd_timeout_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            tff_we_q     <= 1'b0;
            tff_re_q     <= 1'b0;
            tff_rstb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdata_q      <= wdata_d;
            ph_cnt_q     <= ph_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            base_q       <= base_d;
            sync_q       <= sync_d;
            rd_data_q    <= rd_data_d;
            rd_timeout_q <= rd_timeout_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            tff_we_q     <= tff_we_d;
            tff_re_q     <= tff_re_d;
            tff_rstb_q   <= tff_rstb_d;
        end
    end

    assign busy       = busy_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_timeout = rd_timeout_q;
    assign tff_we     = tff_we_q;
    assign tff_re     = tff_re_q;
    assign tff_rstb   = tff_rstb_q;

endmodule

// File: tb/tb_tff_ctrl.sv
// Directed and randomized bench for tff_ctrl; expected behaviour comes from
// cycle counts derived directly from the write/read rules.
module tb_tff_ctrl;

    localparam int DATA_W      = 4;
    localparam int UNIT_CYC    = 1;
    localparam int CLR_CYC     = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int RD_MAX      = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              wr_req = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_req = 1'b0;
    logic              tff_out = 1'b0;
    logic              busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_timeout;
    logic              tff_we;
    logic              tff_re;
    logic              tff_rstb;

    int tests_run    = 0;
    int tests_failed = 0;
    int last_rd_data = 0;
    int last_rd_tmo  = 0;

    tff_ctrl #(
        .DATA_W      (DATA_W),
        .UNIT_CYC    (UNIT_CYC),
        .CLR_CYC     (CLR_CYC),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_timeout (rd_timeout),
        .tff_we     (tff_we),
        .tff_re     (tff_re),
        .tff_rstb   (tff_rstb),
        .tff_out    (tff_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        wr_req  = wr;
        rd_req  = rd;
        wr_data = d;
    endtask

    // Write: CLR_CYC cycles of cell reset, then d*UNIT_CYC cycles of tff_we.
    task automatic do_write(input int d, input bit rd_too, input bit rd_during);
        int we_cycles;
        we_cycles = d * UNIT_CYC;
        applyStimulus(1'b1, rd_too, DATA_W'(d));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < CLR_CYC; c++) begin
            checkOutput("clr_rstb", 32'(tff_rstb), 32'd0);
            checkOutput("clr_we",   32'(tff_we),   32'd0);
            checkOutput("clr_re",   32'(tff_re),   32'd0);
            checkOutput("clr_busy", 32'(busy),     32'd1);
            @(negedge clk);
        end
        for (int c = 0; c < we_cycles; c++) begin
            checkOutput("wr_we",   32'(tff_we),   32'd1);
            checkOutput("wr_rstb", 32'(tff_rstb), 32'd1);
            checkOutput("wr_re",   32'(tff_re),   32'd0);
            checkOutput("wr_busy", 32'(busy),     32'd1);
            rd_req = rd_during && (c == 0);
            @(negedge clk);
        end
        rd_req = 1'b0;
        checkOutput("wr_end_busy", 32'(busy),     32'd0);
        checkOutput("wr_end_we",   32'(tff_we),   32'd0);
        checkOutput("wr_end_rstb", 32'(tff_rstb), 32'd1);
        checkOutput("wr_hold_rd",  32'(rd_data),  32'(last_rd_data));
        @(negedge clk);
        checkOutput("wr_after_re",   32'(tff_re), 32'd0);
        checkOutput("wr_after_busy", 32'(busy),   32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Read: tff_out toggles just before the j-th edge after tff_re rises, so the
    // change is visible after SYNC_STAGES more edges and the read lasts j+SYNC_STAGES cycles.
    task automatic do_read(input int j, input bit toggle, input bit wr_poke);
        int  n;
        bit  hit;
        hit = toggle && (j + SYNC_STAGES <= TIMEOUT_CYC);
        n   = hit ? j + SYNC_STAGES : TIMEOUT_CYC;
        applyStimulus(1'b0, 1'b1, '0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        for (int k = 0; k < n; k++) begin
            checkOutput("rd_re",    32'(tff_re),   32'd1);
            checkOutput("rd_we",    32'(tff_we),   32'd0);
            checkOutput("rd_busy",  32'(busy),     32'd1);
            checkOutput("rd_valid", 32'(rd_valid), 32'd0);
            if (wr_poke && k == 2)
                applyStimulus(1'b1, 1'b0, DATA_W'($urandom_range(1, RD_MAX)));
            else
                applyStimulus(1'b0, 1'b0, '0);
            if (toggle && k == j - 1)
                tff_out = ~tff_out;
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, '0);
        last_rd_data = (n > RD_MAX) ? RD_MAX : n;
        last_rd_tmo  = hit ? 0 : 1;
        checkOutput("done_valid", 32'(rd_valid),   32'd1);
        checkOutput("done_re",    32'(tff_re),     32'd0);
        checkOutput("done_busy",  32'(busy),       32'd1);
        checkOutput("done_data",  32'(rd_data),    32'(last_rd_data));
        checkOutput("done_tmo",   32'(rd_timeout), 32'(last_rd_tmo));
        @(negedge clk);
        checkOutput("post_valid", 32'(rd_valid),   32'd0);
        checkOutput("post_busy",  32'(busy),       32'd0);
        checkOutput("post_data",  32'(rd_data),    32'(last_rd_data));
        checkOutput("post_tmo",   32'(rd_timeout), 32'(last_rd_tmo));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #12;
        checkOutput("rst_busy",  32'(busy),       32'd0);
        checkOutput("rst_valid", 32'(rd_valid),   32'd0);
        checkOutput("rst_data",  32'(rd_data),    32'd0);
        checkOutput("rst_tmo",   32'(rd_timeout), 32'd0);
        checkOutput("rst_we",    32'(tff_we),     32'd0);
        checkOutput("rst_re",    32'(tff_re),     32'd0);
        checkOutput("rst_rstb",  32'(tff_rstb),   32'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        checkOutput("rel_rstb", 32'(tff_rstb), 32'd1);
        checkOutput("rel_busy", 32'(busy),     32'd0);
        repeat (2) @(negedge clk);

        do_write(5, 1'b0, 1'b0);
        do_write(0, 1'b0, 1'b0);
        do_read(10, 1'b1, 1'b0);
        do_read(1, 1'b0, 1'b0);
        do_read(62, 1'b1, 1'b0);
        do_read(63, 1'b1, 1'b0);
        do_write(3, 1'b1, 1'b1);
        do_read(5, 1'b1, 1'b1);
        do_read(14, 1'b1, 1'b0);

        // Reset in the middle of a read: everything drops at once, no rd_valid.
        applyStimulus(1'b0, 1'b1, '0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (4) @(negedge clk);
        checkOutput("mid_re", 32'(tff_re), 32'd1);
        rstb = 1'b0;
        #1;
        checkOutput("abort_busy",  32'(busy),       32'd0);
        checkOutput("abort_re",    32'(tff_re),     32'd0);
        checkOutput("abort_we",    32'(tff_we),     32'd0);
        checkOutput("abort_rstb",  32'(tff_rstb),   32'd0);
        checkOutput("abort_valid", 32'(rd_valid),   32'd0);
        checkOutput("abort_data",  32'(rd_data),    32'd0);
        checkOutput("abort_tmo",   32'(rd_timeout), 32'd0);
        @(negedge clk);
        checkOutput("abort_valid2", 32'(rd_valid), 32'd0);
        rstb = 1'b1;
        @(negedge clk);
        checkOutput("rerel_rstb",  32'(tff_rstb), 32'd1);
        checkOutput("rerel_busy",  32'(busy),     32'd0);
        checkOutput("rerel_valid", 32'(rd_valid), 32'd0);
        last_rd_data = 0;
        last_rd_tmo  = 0;
        repeat (3) @(negedge clk);
        do_read(7, 1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(int'($urandom_range(0, RD_MAX)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            else
                do_read(int'($urandom_range(1, 70)), ($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tff_ctrl.md
TFF_CTRL -- requirements
Module: tff_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: width of write value and read result.
REQ-002 Parameter UNIT_CYC, default 1: clk cycles of tff_we per unit of wr_data; legal range 1..255.
REQ-003 Parameter CLR_CYC, default 2: clk cycles tff_rstb is held low before each write; legal range 1..255.
REQ-004 Parameter SYNC_STAGES, default 2: flip-flop stages synchronizing tff_out; minimum 2.
REQ-005 Parameter TIMEOUT_CYC, default 64: maximum READ-state cycles before the read is aborted; legal range 1..65535.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rstb  input  1  reset, asynchronous, active-low.
REQ-008 wr_req  input  1  one-cycle write request, sampled in IDLE only.
REQ-009 wr_data  input  DATA_W  value to store as WE pulse length, sampled with wr_req.
REQ-010 rd_req  input  1  one-cycle read request, sampled in IDLE only.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 rd_valid  output  1  one-cycle pulse when rd_data/rd_timeout are updated.
REQ-013 rd_data  output  DATA_W  measured read time in clk cycles, saturated.
REQ-014 rd_timeout  output  1  set with rd_valid when the read hit TIMEOUT_CYC.
REQ-015 tff_we  output  1  write-enable to the ring-oscillator cell, registered.
REQ-016 tff_re  output  1  read-enable to the cell, registered.
REQ-017 tff_rstb  output  1  active-low reset to the cell, registered.
REQ-018 tff_out  input  1  cell output, asynchronous to clk.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, WRITE, READ, DONE.
REQ-020 In IDLE with wr_req=1, the block SHALL latch wr_data and enter CLEAR on that edge; wr_req SHALL have priority over a simultaneous rd_req, which is dropped.
REQ-021 In IDLE with rd_req=1 and wr_req=0, the block SHALL enter READ on that edge.
REQ-022 Requests arriving while busy=1 SHALL be ignored without side effects.
REQ-023 CLEAR SHALL drive tff_rstb=0, tff_we=0, tff_re=0 for exactly CLR_CYC cycles, then go to WRITE, or to IDLE if the latched wr_data is 0.
REQ-024 WRITE SHALL drive tff_we=1, tff_rstb=1 for exactly wr_data*UNIT_CYC cycles, then return to IDLE with tff_we=0.
REQ-025 On READ entry the block SHALL capture the synchronized tff_out as baseline and clear a cycle counter of width ceil(log2(TIMEOUT_CYC+1)).
REQ-026 READ SHALL drive tff_re=1 and increment the counter by 1 per cycle.
REQ-027 READ SHALL exit to DONE on the first cycle in which synchronized tff_out differs from baseline, or when the counter equals TIMEOUT_CYC, whichever occurs first; tff_re SHALL be 0 in DONE.
REQ-028 In DONE, rd_data SHALL load min(counter, 2^DATA_W-1), rd_timeout SHALL load 1 only if exit was by timeout, and rd_valid SHALL pulse for one cycle; the FSM SHALL then return to IDLE.
REQ-029 If an edge and timeout coincide, the edge SHALL win and rd_timeout=0.
REQ-030 rd_data and rd_timeout SHALL hold their value until the next DONE.
REQ-031 tff_out SHALL be used only through the SYNC_STAGES synchronizer; no combinational path from tff_out to any output.
REQ-032 tff_we and tff_re SHALL never be high in the same cycle.

Reset
REQ-033 While rstb=0: state=IDLE, busy=0, rd_valid=0, rd_data=0, rd_timeout=0, tff_we=0, tff_re=0, tff_rstb=0, synchronizer and counters cleared.
REQ-034 tff_rstb SHALL go 1 on the first clk edge after rstb deasserts.
REQ-035 Reset asserted mid-operation SHALL abort immediately with the REQ-033 values; no rd_valid pulse is produced for the aborted read.

Verification
REQ-036 Write wr_data=5, UNIT_CYC=1, CLR_CYC=2 -> tff_rstb low 2 cycles, then tff_we high exactly 5 cycles, busy high 7 cycles total.
REQ-037 Write wr_data=0 -> CLR_CYC cycles of tff_rstb low, tff_we never asserted, return to IDLE.
REQ-038 Read with model toggling tff_out 10 cycles after tff_re rises -> rd_valid pulse, rd_data=10+SYNC_STAGES (saturating to 15 for DATA_W=4), rd_timeout=0.
REQ-039 Read with tff_out static, TIMEOUT_CYC=64 -> tff_re high 64 cycles, rd_valid with rd_data=15, rd_timeout=1.
REQ-040 wr_req and rd_req in same IDLE cycle, then rd_req during WRITE -> write executes, no READ entered, tff_re stays 0.
REQ-041 rstb pulsed low in middle of READ -> all outputs at reset values asynchronously, no rd_valid, next read works normally.
